// File: rtl/inst_fetcher.sv
// Instruction fetch unit: fetch PC, direct-mapped word cache, RVC/32-bit assembly
// (including word-straddling instructions) and static next-PC prediction.
// Optional: define FETCH_BRANCH_PREDICT_EN for backward-taken conditional branch
// prediction; without it all conditional branches are predicted not-taken.
module inst_fetcher #(
  parameter logic [31:0]  RESET_PC        = 32'h0,
  parameter int unsigned  ICACHE_IDX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] predict_nxt_pc,
  input  logic        dec_stall,
  input  logic        dec_clear,
  input  logic [31:0] dec_new_addr,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_addr
);

  localparam int unsigned NumLines = 1 << ICACHE_IDX_BITS;
  localparam int unsigned TagBits  = 30 - ICACHE_IDX_BITS;

  typedef enum logic [1:0] {StFetch, StMissLo, StMissHi, StWaitJalr} state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic        ins_ready_q, ins_ready_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pnpc_q, pnpc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic [NumLines-1:0] valid_q;
  logic [31:0]         data_q [NumLines];
  logic [TagBits-1:0]  tag_q  [NumLines];

  // Cache lookup of the word at fpc (A) and the following word (A+1)
  logic [29:0]                word_a, word_b;
  logic [ICACHE_IDX_BITS-1:0] idx_a, idx_b, fill_idx;
  logic [TagBits-1:0]         fill_tag;
  logic [31:0]                data_a, data_b;
  logic                       hit_a, hit_b, fill_en;

  assign word_a   = fpc_q[31:2];
  assign word_b   = word_a + 30'd1;
  assign idx_a    = word_a[ICACHE_IDX_BITS-1:0];
  assign idx_b    = word_b[ICACHE_IDX_BITS-1:0];
  assign data_a   = data_q[idx_a];
  assign data_b   = data_q[idx_b];
  assign hit_a    = valid_q[idx_a] && (tag_q[idx_a] == word_a[29:ICACHE_IDX_BITS]);
  assign hit_b    = valid_q[idx_b] && (tag_q[idx_b] == word_b[29:ICACHE_IDX_BITS]);
  // The outstanding request address already names the line being refilled
  assign fill_idx = req_addr_q[ICACHE_IDX_BITS+1:2];
  assign fill_tag = req_addr_q[31:ICACHE_IDX_BITS+2];

  // Instruction assembly; a 32-bit instruction at fpc[1]=1 takes its upper half from A+1
  logic [15:0] half_lo;
  logic        is_32, need_b;
  logic [31:0] asm_ins;

  assign half_lo = fpc_q[1] ? data_a[31:16] : data_a[15:0];
  assign is_32   = (half_lo[1:0] == 2'b11);
  assign need_b  = fpc_q[1] && is_32;
  assign asm_ins = !is_32   ? {16'h0, half_lo} :
                   fpc_q[1] ? {data_b[15:0], half_lo} : data_a;

  logic unused_data_b;
  assign unused_data_b = ^data_b[31:16];

  logic bp_en;
`ifdef FETCH_BRANCH_PREDICT_EN
  assign bp_en = 1'b1;
`else
  assign bp_en = 1'b0;
`endif

  // Static prediction from the assembled instruction
  logic [31:0] imm_j, imm_b, imm_cj, imm_cb, offset, next_pc;
  logic        is_jump, is_back_br, is_jalr, cond_taken;

  assign imm_j  = {{12{asm_ins[31]}}, asm_ins[19:12], asm_ins[20], asm_ins[30:21], 1'b0};
  assign imm_b  = {{20{asm_ins[31]}}, asm_ins[7], asm_ins[30:25], asm_ins[11:8], 1'b0};
  assign imm_cj = {{21{asm_ins[12]}}, asm_ins[8], asm_ins[10:9], asm_ins[6], asm_ins[7],
                   asm_ins[2], asm_ins[11], asm_ins[5:3], 1'b0};
  assign imm_cb = {{24{asm_ins[12]}}, asm_ins[6:5], asm_ins[2], asm_ins[11:10],
                   asm_ins[4:3], 1'b0};

  // Classify the assembled instruction and pick the next fetch offset
  always_comb begin
    is_jump    = 1'b0;
    is_back_br = 1'b0;
    is_jalr    = 1'b0;
    offset     = is_32 ? 32'd4 : 32'd2;
    if (is_32) begin
      case (asm_ins[6:0])
        7'b1101111: begin
          is_jump = 1'b1;
          offset  = imm_j;
        end
        7'b1100011: is_back_br = asm_ins[31];
        7'b1100111: is_jalr = 1'b1;
        default: ;
      endcase
    end else begin
      case ({asm_ins[15:13], asm_ins[1:0]})
        5'b101_01, 5'b001_01: begin  // C.J, C.JAL
          is_jump = 1'b1;
          offset  = imm_cj;
        end
        5'b110_01, 5'b111_01: is_back_br = asm_ins[12];  // C.BEQZ, C.BNEZ
        5'b100_10: is_jalr = (asm_ins[11:7] != 5'd0) && (asm_ins[6:2] == 5'd0);
        default: ;
      endcase
    end
    cond_taken = is_back_br && bp_en;
    if (cond_taken) offset = is_32 ? imm_b : imm_cb;
  end

  assign next_pc = fpc_q + offset;

  // Next-state: redirects first, then stall hold, then the fetch FSM
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    ins_ready_d = ins_ready_q;
    ins_d       = ins_q;
    pc_d        = pc_q;
    pnpc_d      = pnpc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    fill_en     = 1'b0;
    if (rdy_in) begin
      if (rob_clear || dec_clear) begin
        fpc_d       = rob_clear ? rob_new_addr : dec_new_addr;
        state_d     = StFetch;
        ins_ready_d = 1'b0;
        req_valid_d = 1'b0;
      end else if (dec_stall && ins_ready_q) begin
        // Decoder has not taken the presented instruction: hold everything
        state_d = state_q;
      end else begin
        unique case (state_q)
          StFetch: begin
            ins_ready_d = 1'b0;
            if (!hit_a) begin
              state_d     = StMissLo;
              req_valid_d = 1'b1;
              req_addr_d  = {word_a, 2'b00};
            end else if (need_b && !hit_b) begin
              state_d     = StMissHi;
              req_valid_d = 1'b1;
              req_addr_d  = {word_b, 2'b00};
            end else begin
              ins_ready_d = 1'b1;
              ins_d       = asm_ins;
              pc_d        = {fpc_q[31:1], cond_taken};
              pnpc_d      = next_pc;
              fpc_d       = next_pc;
              if (is_jalr) state_d = StWaitJalr;
            end
          end
          StMissLo, StMissHi: begin
            if (mem_resp_valid) begin
              fill_en     = 1'b1;
              req_valid_d = 1'b0;
              state_d     = StFetch;
            end
          end
          StWaitJalr: ins_ready_d = 1'b0;
          default: state_d = StFetch;
        endcase
      end
    end
  end

  // Control state and cache valid bits
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StFetch;
      fpc_q       <= RESET_PC;
      ins_ready_q <= 1'b0;
      ins_q       <= 32'h0;
      pc_q        <= 32'h0;
      pnpc_q      <= 32'h0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      ins_ready_q <= ins_ready_d;
      ins_q       <= ins_d;
      pc_q        <= pc_d;
      pnpc_q      <= pnpc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Cache data and tag storage (no reset; qualified by valid bits)
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      data_q[fill_idx] <= mem_resp_data;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  assign mem_req_valid  = req_valid_q;
  assign mem_req_addr   = req_addr_q;
  assign ins_ready      = ins_ready_q;
  assign ins            = ins_q;
  assign pc             = pc_q;
  assign predict_nxt_pc = pnpc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: directed programs in a behavioural memory,
// expected instructions queued up front and checked by a decoupled monitor.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        ins_ready;
  logic [31:0] ins, pc, predict_nxt_pc;
  logic        dec_stall = 1'b0;
  logic        dec_clear = 1'b0;
  logic [31:0] dec_new_addr = 32'h0;
  logic        rob_clear = 1'b0;
  logic [31:0] rob_new_addr = 32'h0;

  localparam logic [31:0] Jalr = 32'h00008067;

  inst_fetcher dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .pc             (pc),
    .predict_nxt_pc (predict_nxt_pc),
    .dec_stall      (dec_stall),
    .dec_clear      (dec_clear),
    .dec_new_addr   (dec_new_addr),
    .rob_clear      (rob_clear),
    .rob_new_addr   (rob_new_addr)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pnpc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  logic [31:0] mem [256];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h, want %08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (i < req_q.size()) ? req_q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [31:0] n);
    exp_t e;
    e.ins  = i;
    e.pc   = p;
    e.pnpc = n;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Hold reset, clear memory to JALRs and empty the request log
  task automatic start_reset();
    rst_in = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = Jalr;
    req_q.delete();
    tick();
    tick();
  endtask

  // Release reset; a nonzero start address is applied by a ROB flush on the first edge
  task automatic release_reset(input logic [31:0] start);
    rst_in       = 1'b1;
    rob_clear    = (start != 32'h0);
    rob_new_addr = start;
    tick();
    rob_clear = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int k = 0; k < 8; k++) tick();
  endtask

  // Memory model: answers a held request one cycle after seeing it, with a single pulse
  initial begin
    int lat = 0;
    forever begin
      @(posedge clk_in);
      #1;
      mem_resp_valid = 1'b0;
      if (rst_in && rdy_in && mem_req_valid) begin
        if (lat >= 1) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem[mem_req_addr[9:2]];
          req_q.push_back(mem_req_addr);
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Monitor: every accepted instruction is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in && ins_ready && !dec_stall) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ins: got ins %08h pc %08h, want none", ins, pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_ins", ins, e.ins);
          check("sb_pc", pc, e.pc);
          check("sb_pnpc", predict_nxt_pc, e.pnpc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    // Asynchronous reset, checked before any clock edge
    #2 rst_in = 1'b0;
    #1;
    check("rst_ins_ready", {31'h0, ins_ready}, 32'h0);
    check("rst_ins", ins, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pnpc", predict_nxt_pc, 32'h0);
    check("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("rst_req_addr", mem_req_addr, 32'h0);

    // 1: single 32-bit instruction after a miss, with response-to-present latency
    start_reset();
    mem[0] = 32'h00500093;
    push(32'h00500093, 32'h0, 32'h4);
    push(Jalr, 32'h4, 32'h8);
    release_reset(32'h0);
    n = 0;
    while (!mem_resp_valid && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    check("t1_resp_seen", {31'h0, mem_resp_valid}, 32'h1);
    tick();
    check("t1_ready_early", {31'h0, ins_ready}, 32'h0);
    tick();
    check("t1_ready_2cyc", {31'h0, ins_ready}, 32'h1);
    drain("t1_drain");
    check("t1_req0", req_at(0), 32'h0);

    // 2: two RVC halves then a 32-bit word
    start_reset();
    mem[0] = 32'h00014501;
    mem[1] = 32'h00000013;
    push(32'h00004501, 32'h0, 32'h2);
    push(32'h00000001, 32'h2, 32'h4);
    push(32'h00000013, 32'h4, 32'h8);
    push(Jalr, 32'h8, 32'hC);
    release_reset(32'h0);
    drain("t2_drain");

    // 3: straddling 32-bit instruction at 2 (MISS_LO then MISS_HI), rdy_in freeze, C.JR
    start_reset();
    mem[0] = 32'h01130001;
    mem[1] = 32'h808200A0;
    push(32'h00A00113, 32'h2, 32'h6);
    push(32'h00008082, 32'h6, 32'h8);
    release_reset(32'h2);
    n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_frz_req", {31'h0, mem_req_valid}, 32'h1);
      check("t3_frz_addr", mem_req_addr, 32'h0);
    end
    rdy_in = 1'b1;
    drain("t3_drain");
    check("t3_nreq", 32'(req_q.size()), 32'd2);
    check("t3_req0", req_at(0), 32'h0);
    check("t3_req1", req_at(1), 32'h4);

    // 4: backward beq (-8) at 0x10
    start_reset();
    mem[4] = 32'hFE000CE3;
`ifdef FETCH_BRANCH_PREDICT_EN
    push(32'hFE000CE3, 32'h11, 32'h08);
    push(Jalr, 32'h08, 32'h0C);
`else
    push(32'hFE000CE3, 32'h10, 32'h14);
    push(Jalr, 32'h14, 32'h18);
`endif
    release_reset(32'h10);
    drain("t4_drain");

    // 5: JAL +0x20 at 0x20 is always followed
    start_reset();
    mem[8] = 32'h0200006F;
    push(32'h0200006F, 32'h20, 32'h40);
    push(Jalr, 32'h40, 32'h44);
    release_reset(32'h20);
    drain("t5_drain");

    // 6: straddle across the cache index wrap (word 63 -> word 64)
    start_reset();
    mem[63] = 32'h01130001;
    mem[64] = 32'h808200A0;
    push(32'h00A00113, 32'hFE, 32'h102);
    push(32'h00008082, 32'h102, 32'h104);
    release_reset(32'hFE);
    drain("t6_drain");
    check("t6_req0", req_at(0), 32'hFC);
    check("t6_req1", req_at(1), 32'h100);

    // 7: stall hold, WAIT_JALR quiet, clear priority, JALR redirect
    start_reset();
    mem[0]  = 32'h00500093;
    mem[1]  = 32'h00000013;
    mem[16] = 32'h00000013;
    mem[32] = 32'h00100093;
    push(32'h00500093, 32'h0, 32'h4);
    push(32'h00000013, 32'h4, 32'h8);
    push(Jalr, 32'h8, 32'hC);
    dec_stall = 1'b1;
    release_reset(32'h0);
    n = 0;
    while (!ins_ready && n < 40) begin
      tick();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      check("t7_stall_rdy", {31'h0, ins_ready}, 32'h1);
      check("t7_stall_ins", ins, 32'h00500093);
      check("t7_stall_pc", pc, 32'h0);
      check("t7_stall_pnpc", predict_nxt_pc, 32'h4);
      check("t7_stall_req", {31'h0, mem_req_valid}, 32'h0);
      tick();
    end
    dec_stall = 1'b0;
    drain("t7_drain_a");
    snap = req_q.size();
    for (int k = 0; k < 10; k++) tick();
    check("t7_wait_nreq", 32'(req_q.size()), 32'(snap));
    check("t7_wait_req", {31'h0, mem_req_valid}, 32'h0);
    check("t7_wait_rdy", {31'h0, ins_ready}, 32'h0);
    push(32'h00000013, 32'h40, 32'h44);
    push(Jalr, 32'h44, 32'h48);
    rob_clear    = 1'b1;
    rob_new_addr = 32'h40;
    dec_clear    = 1'b1;
    dec_new_addr = 32'h80;
    tick();
    rob_clear = 1'b0;
    dec_clear = 1'b0;
    drain("t7_drain_b");
    push(Jalr, 32'h100, 32'h104);
    dec_clear    = 1'b1;
    dec_new_addr = 32'h100;
    tick();
    dec_clear = 1'b0;
    drain("t7_drain_c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
